// File: rtl/coef_frame_commit_if.sv
// Shadow/active coefficient bank bus: software write side plus
// the active bank, commit and frame status seen by the filter.
interface coef_frame_commit_if #(
  parameter int NUM_COEF   = 25,
  parameter int COEF_WIDTH = 10,
  parameter int ADDR_WIDTH = 5,
  parameter int FCNT_WIDTH = 16
);
  logic                           i_wr_en;
  logic [ADDR_WIDTH-1:0]          i_wr_addr;
  logic [COEF_WIDTH-1:0]          i_wr_data;
  logic                           i_commit;
  logic                           i_abort;
  logic                           i_vs;
  logic [NUM_COEF*COEF_WIDTH-1:0] o_coef;
  logic                           o_bypass;
  logic                           o_pending;
  logic                           o_commit_done;
  logic                           o_wr_err;
  logic [FCNT_WIDTH-1:0]          o_frame_cnt;
`ifdef COEF_READBACK_EN
  logic [ADDR_WIDTH-1:0]          i_rd_addr;
  logic                           i_rd_sel;
  logic [COEF_WIDTH-1:0]          o_rd_data;
`endif

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data,
    output i_commit, i_abort, i_vs,
`ifdef COEF_READBACK_EN
    output i_rd_addr, i_rd_sel,
    input  o_rd_data,
`endif
    input  o_coef, o_bypass, o_pending,
    input  o_commit_done, o_wr_err, o_frame_cnt
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data,
    input  i_commit, i_abort, i_vs,
`ifdef COEF_READBACK_EN
    input  i_rd_addr, i_rd_sel,
    output o_rd_data,
`endif
    output o_coef, o_bypass, o_pending,
    output o_commit_done, o_wr_err, o_frame_cnt
  );
endinterface

// File: rtl/coef_frame_commit.sv
// Frame-synchronous shadow/active coefficient bank for one 5x5 stage.
// Optional register readback port: define COEF_READBACK_EN.
module coef_frame_commit #(
  parameter int NUM_COEF   = 25,
  parameter int COEF_WIDTH = 10,
  parameter int ADDR_WIDTH = 5,
  parameter int FCNT_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rstn,
  coef_frame_commit_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] BYP_ADDR = ADDR_WIDTH'(NUM_COEF);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t                         state;
  logic [COEF_WIDTH-1:0]          shadow [NUM_COEF];
  logic                           sh_bypass;
  logic [NUM_COEF*COEF_WIDTH-1:0] act_coef;
  logic                           act_bypass;
  logic                           pending;
  logic                           commit_done;
  logic                           wr_err;
  logic [FCNT_WIDTH-1:0]          frame_cnt;
  logic                           r_vs_d;
  logic                           vs_rise;
  logic                           wr_ok;

  assign vs_rise = bus.i_vs & ~r_vs_d;
  assign wr_ok   = bus.i_wr_en && (bus.i_wr_addr <= BYP_ADDR);

  assign bus.o_coef        = act_coef;
  assign bus.o_bypass      = act_bypass;
  assign bus.o_pending     = pending;
  assign bus.o_commit_done = commit_done;
  assign bus.o_wr_err      = wr_err;
  assign bus.o_frame_cnt   = frame_cnt;

  // Shadow bank: software writes land here in any state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_COEF; k++)
        shadow[k] <= '0;
      sh_bypass <= 1'b1;
    end else if (wr_ok) begin
      for (int k = 0; k < NUM_COEF; k++)
        if (bus.i_wr_addr == ADDR_WIDTH'(k))
          shadow[k] <= bus.i_wr_data;
      if (bus.i_wr_addr == BYP_ADDR)
        sh_bypass <= bus.i_wr_data[0];
    end
  end

  // Frame-start detect, frame counter and illegal-write flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vs_d    <= 1'b0;
      frame_cnt <= '0;
      wr_err    <= 1'b0;
    end else begin
      r_vs_d <= bus.i_vs;
      wr_err <= bus.i_wr_en && (bus.i_wr_addr > BYP_ADDR);
      if (vs_rise)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Commit FSM; the copy reads shadow before any same-cycle write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      pending     <= 1'b0;
      commit_done <= 1'b0;
      act_coef    <= '0;
      act_bypass  <= 1'b1;
    end else begin
      commit_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_commit) begin
            state   <= ARMED;
            pending <= 1'b1;
          end
        end
        ARMED: begin
          if (vs_rise) begin
            for (int k = 0; k < NUM_COEF; k++)
              act_coef[k*COEF_WIDTH +: COEF_WIDTH] <= shadow[k];
            act_bypass  <= sh_bypass;
            commit_done <= 1'b1;
            state       <= IDLE;
            pending     <= 1'b0;
          end else if (bus.i_abort) begin
            state   <= IDLE;
            pending <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= 1'b0;
        end
      endcase
    end
  end

`ifdef COEF_READBACK_EN
  logic [COEF_WIDTH-1:0] rd_data;

  assign bus.o_rd_data = rd_data;

  // Registered readback of either bank; illegal addresses read 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
    end else begin
      rd_data <= '0;
      for (int k = 0; k < NUM_COEF; k++)
        if (bus.i_rd_addr == ADDR_WIDTH'(k))
          rd_data <= bus.i_rd_sel ?
                     act_coef[k*COEF_WIDTH +: COEF_WIDTH] :
                     shadow[k];
      if (bus.i_rd_addr == BYP_ADDR)
        rd_data <= COEF_WIDTH'(bus.i_rd_sel ? act_bypass : sh_bypass);
    end
  end
`endif
endmodule
